wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
Sequencer for one wash programme: FILL, WASH, DRAIN1, RINSE, DRAIN2, SPIN, DONE. An internal prescaler generates time-unit ticks. Each phase counts its remaining duration down as a two-digit BCD value, which drives the display digits. The block also drives the actuator enables and sits between the front-panel buttons and the valve, motor and display logic.

Parameters:
TICK_DIV, 100000000, clock cycles per time unit; legal range 1 or more.
FILL_T, 2, FILL duration in time units (binary 1..99).
WASH_T_NORM, 15, WASH duration for mode 00 and mode 11.
WASH_T_QUICK, 5, WASH duration for mode 01.
WASH_T_HEAVY, 30, WASH duration for mode 10.
DRAIN_T, 1, duration of each of DRAIN1 and DRAIN2.
RINSE_T, 8, RINSE duration.
SPIN_T, 6, SPIN duration.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start request; level sampled every cycle
pause  in  1  level; freezes the programme while high
abort  in  1  level; cancels the programme
mode  in  2  programme select; latched at start
phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN1, 4 RINSE, 5 DRAIN2, 6 SPIN, 7 DONE
water_in  out  1  inlet valve enable
drain  out  1  drain pump enable
motor_on  out  1  drum motor enable
motor_fast  out  1  high-speed spin select
paused  out  1  high while the programme is active and paused
done  out  1  programme complete
rem_tens  out  4  BCD tens digit of remaining time units in the current phase
rem_ones  out  4  BCD ones digit of remaining time units in the current phase

Behaviour:
- Clocking and reset: one clock, asynchronous active-low reset. Reset forces every output to 0, phase to IDLE and the prescaler to 0. All outputs are registered.
- Active phases: FILL through SPIN.
- Start:
  - Legal only in IDLE or DONE.
  - The cycle after start is sampled high: phase=FILL, remaining=FILL_T, prescaler=0, mode latched, done=0.
  - Start is ignored in active phases.
- Prescaler:
  - Runs 0..TICK_DIV-1 only while active and not paused.
  - A tick occurs in the cycle the prescaler count is TICK_DIV-1; the prescaler wraps to 0 on that cycle.
- Tick handling:
  - Remaining greater than 1: remaining decrements by 1 in BCD (ones 0 becomes 9 with a borrow from tens).
  - Remaining equal to 1: advance to the next phase and load that phase's duration.
  - SPIN advances to DONE with remaining 00.
  - Each phase therefore lasts exactly duration × TICK_DIV cycles.
- Duration rules: a duration parameter of 0 is treated as 1. Durations are converted from binary to BCD at load time.
- Actuator outputs (all 0 outside the listed phases):
  - FILL: water_in.
  - WASH: motor_on.
  - DRAIN1: drain.
  - RINSE: water_in and motor_on.
  - DRAIN2: drain.
  - SPIN: motor_on, motor_fast and drain.
- Pause:
  - While pause is high in an active phase: prescaler and remaining hold, water_in, motor_on and motor_fast are forced 0, drain holds its phase value, paused=1.
  - On release, counting resumes from the held prescaler value.
  - Pause has no effect in IDLE or DONE.
- Abort:
  - In any active phase or DONE, the cycle after abort is sampled high: phase=IDLE, all outputs 0, remaining 00, prescaler 0.
- Priority within one cycle: abort > pause > tick > start.
  - Abort together with start in IDLE or DONE: stay in or go to IDLE.
- DONE: done=1, remaining 00, actuators 0. DONE holds until start or abort.
- IDLE: rem_tens and rem_ones are 00.
- Reset mid-operation: immediate return to the reset state; no partial state is retained.

Test Plan:
- Full programme: TICK_DIV=4, FILL_T=2, WASH_T_QUICK=3, DRAIN_T=1, RINSE_T=2, SPIN_T=2, mode=01, start pulsed at cycle k.
  - Expect phase=1 at k+1, phase=2 at k+9, phase=3 at k+21, phase=4 at k+25, phase=5 at k+33, phase=6 at k+37, phase=7 with done=1 at k+45.
  - Actuator outputs must match the phase table throughout.
- BCD display: WASH_T_NORM=15, TICK_DIV=2, mode=00.
  - On entering WASH expect 1/5, then 1/4 … 1/0, 0/9 … 0/1, each value held for 2 cycles.
- Pause: assert pause for 10 cycles mid-WASH.
  - paused=1 and motor_on=0 during the pause.
  - Remaining and prescaler are unchanged at release.
  - The WASH exit cycle is delayed by exactly 10 cycles.
- Abort: assert abort during RINSE.
  - Next cycle: phase=0, all outputs 0, 00 displayed.
  - A subsequent start begins FILL normally.
- Ignored inputs and simultaneous events:
  - Start pulsed during WASH: no effect.
  - Abort and start together in DONE: IDLE results.
  - Mode=11 gives WASH duration WASH_T_NORM.
- Reset: drop rst_n asynchronously mid-SPIN.
  - Outputs go to 0 without waiting for a clock edge.
  - After release the block stays in IDLE until start.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Purpose: wash programme sequencer FILL-WASH-DRAIN1-RINSE-DRAIN2-SPIN-DONE with BCD countdown per phase.
// Latency: inputs sampled on a clock edge take effect on the registered outputs that same edge (1 cycle).
// Backpressure: pause freezes prescaler and countdown; abort returns to IDLE; start accepted only in IDLE/DONE.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, pause, abort     front-panel levels, sampled every cycle (abort > pause > tick > start)
//   mode[1:0]               programme select, latched on start (01 quick, 10 heavy, else normal)
//   phase[2:0]              0 IDLE .. 7 DONE
//   water_in, drain, motor_on, motor_fast   actuator enables
//   paused, done            status
//   rem_tens, rem_ones      BCD remaining time units in the current phase
module wash_cycle_ctrl #(
  parameter int TICK_DIV     = 100000000,
  parameter int FILL_T       = 2,
  parameter int WASH_T_NORM  = 15,
  parameter int WASH_T_QUICK = 5,
  parameter int WASH_T_HEAVY = 30,
  parameter int DRAIN_T      = 1,
  parameter int RINSE_T      = 8,
  parameter int SPIN_T       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [1:0] mode,
  output logic [2:0] phase,
  output logic       water_in,
  output logic       drain,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       paused,
  output logic       done,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_ones
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    WASH   = 3'd2,
    DRAIN1 = 3'd3,
    RINSE  = 3'd4,
    DRAIN2 = 3'd5,
    SPIN   = 3'd6,
    DONE   = 3'd7
  } phase_t;

  // Binary duration to two BCD digits; 0 is promoted to 1 so every phase lasts at least one unit.
  function automatic logic [7:0] to_bcd(input int d);
    int v;
    v = (d < 1) ? 1 : d;
    if (v > 99) v = 99;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Actuator pattern per phase, packed as {water_in, drain, motor_on, motor_fast}.
  function automatic logic [3:0] phase_act(input phase_t p);
    case (p)
      FILL:    return 4'b1000;
      WASH:    return 4'b0010;
      DRAIN1:  return 4'b0100;
      RINSE:   return 4'b1010;
      DRAIN2:  return 4'b0100;
      SPIN:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [7:0] FILL_BCD  = to_bcd(FILL_T);
  localparam logic [7:0] NORM_BCD  = to_bcd(WASH_T_NORM);
  localparam logic [7:0] QUICK_BCD = to_bcd(WASH_T_QUICK);
  localparam logic [7:0] HEAVY_BCD = to_bcd(WASH_T_HEAVY);
  localparam logic [7:0] DRAIN_BCD = to_bcd(DRAIN_T);
  localparam logic [7:0] RINSE_BCD = to_bcd(RINSE_T);
  localparam logic [7:0] SPIN_BCD  = to_bcd(SPIN_T);

  phase_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    mode_q;

  phase_t     next_ph;
  logic [7:0] next_dur;
  logic [7:0] wash_bcd;
  logic [3:0] cur_act;
  logic       active;
  logic       last_unit;

  assign phase     = state;
  assign active    = (state != IDLE) && (state != DONE);
  assign cur_act   = phase_act(state);
  assign last_unit = (rem_tens == 4'd0) && (rem_ones == 4'd1);

  always_comb begin
    wash_bcd = NORM_BCD;
    case (mode_q)
      2'b01:   wash_bcd = QUICK_BCD;
      2'b10:   wash_bcd = HEAVY_BCD;
      default: wash_bcd = NORM_BCD;
    endcase
  end

  // Successor phase and the duration it loads when the current phase expires.
  always_comb begin
    next_ph  = IDLE;
    next_dur = 8'h00;
    case (state)
      FILL:    begin next_ph = WASH;   next_dur = wash_bcd;  end
      WASH:    begin next_ph = DRAIN1; next_dur = DRAIN_BCD; end
      DRAIN1:  begin next_ph = RINSE;  next_dur = RINSE_BCD; end
      RINSE:   begin next_ph = DRAIN2; next_dur = DRAIN_BCD; end
      DRAIN2:  begin next_ph = SPIN;   next_dur = SPIN_BCD;  end
      SPIN:    begin next_ph = DONE;   next_dur = 8'h00;     end
      default: begin next_ph = IDLE;   next_dur = 8'h00;     end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      presc      <= '0;
      mode_q     <= 2'b00;
      rem_tens   <= 4'd0;
      rem_ones   <= 4'd0;
      water_in   <= 1'b0;
      drain      <= 1'b0;
      motor_on   <= 1'b0;
      motor_fast <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // In IDLE this is a no-op that also suppresses a simultaneous start.
      state      <= IDLE;
      presc      <= '0;
      rem_tens   <= 4'd0;
      rem_ones   <= 4'd0;
      water_in   <= 1'b0;
      drain      <= 1'b0;
      motor_on   <= 1'b0;
      motor_fast <= 1'b0;
      paused     <= 1'b0;
      done       <= 1'b0;
    end else if (active && pause) begin
      // Freeze timing; water and motor are safed, the drain pump keeps running if it was.
      paused     <= 1'b1;
      water_in   <= 1'b0;
      motor_on   <= 1'b0;
      motor_fast <= 1'b0;
      drain      <= cur_act[2];
    end else if (active) begin
      paused <= 1'b0;
      if (presc == PRESC_MAX) begin
        presc <= '0;
        if (last_unit) begin
          state <= next_ph;
          {rem_tens, rem_ones} <= next_dur;
          {water_in, drain, motor_on, motor_fast} <= phase_act(next_ph);
          done <= (next_ph == DONE);
        end else begin
          if (rem_ones == 4'd0) begin
            rem_ones <= 4'd9;
            rem_tens <= rem_tens - 4'd1;
          end else begin
            rem_ones <= rem_ones - 4'd1;
          end
          {water_in, drain, motor_on, motor_fast} <= cur_act;
        end
      end else begin
        presc <= presc + 1'b1;
        // Also restores actuators on the first cycle after a pause is released.
        {water_in, drain, motor_on, motor_fast} <= cur_act;
      end
    end else if (start) begin
      state    <= FILL;
      presc    <= '0;
      mode_q   <= mode;
      {rem_tens, rem_ones} <= FILL_BCD;
      {water_in, drain, motor_on, motor_fast} <= phase_act(FILL);
      paused   <= 1'b0;
      done     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Purpose: self-checking bench for wash_cycle_ctrl using a directed vector table plus corner-case sequences.
// Latency: outputs are checked 1 ns after each rising edge; inputs change at the same point.
// Backpressure: none; pause and abort are exercised as directed stimulus.
module tb_wash_cycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] mode;
  logic [2:0] phase;
  logic       water_in;
  logic       drain;
  logic       motor_on;
  logic       motor_fast;
  logic       paused;
  logic       done;
  logic [3:0] rem_tens;
  logic [3:0] rem_ones;

  int checks = 0;
  int errors = 0;

  wash_cycle_ctrl #(
    .TICK_DIV    (4),
    .FILL_T      (2),
    .WASH_T_NORM (15),
    .WASH_T_QUICK(3),
    .WASH_T_HEAVY(12),
    .DRAIN_T     (1),
    .RINSE_T     (2),
    .SPIN_T      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .mode      (mode),
    .phase     (phase),
    .water_in  (water_in),
    .drain     (drain),
    .motor_on  (motor_on),
    .motor_fast(motor_fast),
    .paused    (paused),
    .done      (done),
    .rem_tens  (rem_tens),
    .rem_ones  (rem_ones)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         n;
    logic       start;
    logic       pause;
    logic       abort;
    logic [1:0] mode;
    logic [2:0] ph;
    logic [3:0] t;
    logic [3:0] o;
    logic       dn;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input int n, input int s, input int p, input int a, input int m,
                              input int ph, input int t, input int o, input int dn);
    vec_t v;
    v.n     = n;
    v.start = s[0];
    v.pause = p[0];
    v.abort = a[0];
    v.mode  = m[1:0];
    v.ph    = ph[2:0];
    v.t     = t[3:0];
    v.o     = o[3:0];
    v.dn    = dn[0];
    return v;
  endfunction

  // Reference actuator table {water_in, drain, motor_on, motor_fast}.
  function automatic logic [3:0] exp_act(input logic [2:0] p);
    case (p)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1010;
      3'd5:    return 4'b0100;
      3'd6:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (phase !== target && n < budget) begin
      step();
      n++;
    end
    chk("wait_phase", 8'(phase), 8'(target));
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_phase"}, 8'(phase), 8'd0);
    chk({name, "_rem"}, {rem_tens, rem_ones}, 8'h00);
    chk({name, "_act"}, 8'({water_in, drain, motor_on, motor_fast}), 8'd0);
    chk({name, "_flags"}, 8'({paused, done}), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;

    // Full quick programme with TICK_DIV=4 (unit = 4 cycles); row 0 samples start.
    tbl[0]  = mk(1, 1, 0, 0, 1, 1, 0, 2, 0);   // k+1  FILL 02
    tbl[1]  = mk(3, 0, 0, 0, 1, 1, 0, 2, 0);   // k+4
    tbl[2]  = mk(1, 0, 0, 0, 1, 1, 0, 1, 0);   // k+5  FILL 01
    tbl[3]  = mk(3, 0, 0, 0, 1, 1, 0, 1, 0);   // k+8
    tbl[4]  = mk(1, 0, 0, 0, 1, 2, 0, 3, 0);   // k+9  WASH 03
    tbl[5]  = mk(1, 1, 0, 0, 2, 2, 0, 3, 0);   // start during WASH ignored
    tbl[6]  = mk(10, 0, 0, 0, 1, 2, 0, 1, 0);  // k+20 WASH 01
    tbl[7]  = mk(1, 0, 0, 0, 1, 3, 0, 1, 0);   // k+21 DRAIN1
    tbl[8]  = mk(3, 0, 0, 0, 1, 3, 0, 1, 0);   // k+24
    tbl[9]  = mk(1, 0, 0, 0, 1, 4, 0, 2, 0);   // k+25 RINSE 02
    tbl[10] = mk(7, 0, 0, 0, 1, 4, 0, 1, 0);   // k+32
    tbl[11] = mk(1, 0, 0, 0, 1, 5, 0, 1, 0);   // k+33 DRAIN2
    tbl[12] = mk(3, 0, 0, 0, 1, 5, 0, 1, 0);   // k+36
    tbl[13] = mk(1, 0, 0, 0, 1, 6, 0, 2, 0);   // k+37 SPIN 02
    tbl[14] = mk(7, 0, 0, 0, 1, 6, 0, 1, 0);   // k+44
    tbl[15] = mk(1, 0, 0, 0, 1, 7, 0, 0, 1);   // k+45 DONE
    tbl[16] = mk(5, 0, 1, 0, 1, 7, 0, 0, 1);   // DONE holds, pause ignored
    tbl[17] = mk(1, 1, 0, 1, 1, 0, 0, 0, 0);   // abort+start in DONE -> IDLE
    tbl[18] = mk(3, 0, 0, 0, 1, 0, 0, 0, 0);   // stays IDLE
    tbl[19] = mk(1, 1, 0, 0, 3, 1, 0, 2, 0);   // start with mode 11
    tbl[20] = mk(7, 0, 0, 0, 1, 1, 0, 1, 0);   // mode change after start is not latched
    tbl[21] = mk(1, 0, 0, 0, 1, 2, 1, 5, 0);   // WASH uses normal duration 15

    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    step();
    step();
    chk_idle("post_reset");

    for (int i = 0; i < 22; i++) begin
      start = tbl[i].start;
      pause = tbl[i].pause;
      abort = tbl[i].abort;
      mode  = tbl[i].mode;
      repeat (tbl[i].n) step();
      chk($sformatf("row%0d_phase", i), 8'(phase), 8'(tbl[i].ph));
      chk($sformatf("row%0d_rem", i), {rem_tens, rem_ones}, {tbl[i].t, tbl[i].o});
      chk($sformatf("row%0d_done", i), 8'(done), 8'(tbl[i].dn));
      chk($sformatf("row%0d_paused", i), 8'(paused), 8'd0);
      chk($sformatf("row%0d_act", i), 8'({water_in, drain, motor_on, motor_fast}), 8'(exp_act(tbl[i].ph)));
    end
    start = 1'b0;

    // BCD countdown 15..1 in WASH, each value held for one unit (4 cycles).
    for (int i = 0; i < 60; i++) begin
      int v;
      v = 15 - i / 4;
      chk($sformatf("bcd%0d_phase", i), 8'(phase), 8'd2);
      chk($sformatf("bcd%0d_rem", i), {rem_tens, rem_ones}, {4'(v / 10), 4'(v % 10)});
      step();
    end
    chk("bcd_exit_phase", 8'(phase), 8'd3);
    chk("bcd_exit_rem", {rem_tens, rem_ones}, 8'h01);

    // Abort during RINSE, then a fresh start.
    wait_phase(3'd4, 20);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort");
    start = 1'b1;
    mode  = 2'b01;
    step();
    start = 1'b0;
    chk("restart_phase", 8'(phase), 8'd1);
    chk("restart_rem", {rem_tens, rem_ones}, 8'h02);
    chk("restart_water", 8'(water_in), 8'd1);

    // Pause 10 cycles in WASH starting at cycle 5 of the phase.
    wait_phase(3'd2, 20);
    repeat (5) step();
    chk("pre_pause_rem", {rem_tens, rem_ones}, 8'h02);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("pause%0d_paused", i), 8'(paused), 8'd1);
      chk($sformatf("pause%0d_motor", i), 8'(motor_on), 8'd0);
      chk($sformatf("pause%0d_rem", i), {rem_tens, rem_ones}, 8'h02);
      chk($sformatf("pause%0d_phase", i), 8'(phase), 8'd2);
    end
    pause = 1'b0;
    step();
    chk("resume_paused", 8'(paused), 8'd0);
    chk("resume_motor", 8'(motor_on), 8'd1);
    step();
    chk("resume_rem_held", {rem_tens, rem_ones}, 8'h02);
    step();
    chk("resume_rem_tick", {rem_tens, rem_ones}, 8'h01);
    repeat (3) step();
    chk("wash_last_cycle", 8'(phase), 8'd2);
    step();
    chk("wash_exit_delayed", 8'(phase), 8'd3);
    chk("wash_exit_drain", 8'(drain), 8'd1);

    // Asynchronous reset in the middle of SPIN.
    wait_phase(3'd6, 40);
    step();
    step();
    chk("spin_fast", 8'(motor_fast), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    #2;
    rst_n = 1'b1;
    repeat (5) step();
    chk_idle("reset_release");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("final_start_phase", 8'(phase), 8'd1);
    chk("final_start_rem", {rem_tens, rem_ones}, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
